// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline skid stage and its storage entries.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 4;
  localparam int ADR_W_DEF  = 5;

  // All-zero control marks a bubble: no memory or register write downstream.
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One held pipeline entry {data, adr, ctrl}: load-enabled, with a synchronous
// control clear that turns the entry into a bubble while leaving the payload alone.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W  = ADR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [ADR_W-1:0]  d_adr,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [ADR_W-1:0]  q_adr,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Clear wins over load for control only; payload is don't-care once cleared.
  always_comb begin
    data_d = data_q;
    adr_d  = adr_q;
    ctrl_d = ctrl_q;
    if (load) begin
      data_d = d_data;
      adr_d  = d_adr;
      ctrl_d = d_ctrl;
    end
    if (clear) begin
      ctrl_d = CTRL_W'(CTRL_BUBBLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      adr_q  <= '0;
      ctrl_q <= '0;
    end else begin
      data_q <= data_d;
      adr_q  <= adr_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign q_data = data_q;
  assign q_adr  = adr_q;
  assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage: main drives the outputs, skid absorbs
// one extra entry so in_ready can be a register with no path from out_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int ADR_W  = ADR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADR_W-1:0]  in_adr,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADR_W-1:0]  out_adr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  pipe_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;

  logic in_fire, out_fire;
  logic main_load, skid_load;

  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [ADR_W-1:0]  main_adr, skid_adr, main_d_adr;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_fire) state_d = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_d = FULL;
        else if (!in_fire && out_fire) state_d = EMPTY;
      end
      FULL:    if (out_fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  assign in_ready_d = (state_d != FULL);

  // Main refills from the input except when draining from FULL, where skid moves up.
  always_comb begin
    out_valid = (state_q != EMPTY);
    main_load = 1'b0;
    skid_load = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY:   main_load = in_fire;
        ONE: begin
          main_load = in_fire & out_fire;
          skid_load = in_fire & ~out_fire;
        end
        FULL:    main_load = out_fire;
        default: main_load = 1'b0;
      endcase
    end
    main_d_data = (state_q == FULL) ? skid_data : in_data;
    main_d_adr  = (state_q == FULL) ? skid_adr  : in_adr;
    main_d_ctrl = (state_q == FULL) ? skid_ctrl : in_ctrl;
  end

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .ADR_W  (ADR_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (flush),
    .d_data (main_d_data),
    .d_adr  (main_d_adr),
    .d_ctrl (main_d_ctrl),
    .q_data (main_data),
    .q_adr  (main_adr),
    .q_ctrl (main_ctrl)
  );

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .ADR_W  (ADR_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (flush),
    .d_data (in_data),
    .d_adr  (in_adr),
    .d_ctrl (in_ctrl),
    .q_data (skid_data),
    .q_adr  (skid_adr),
    .q_ctrl (skid_ctrl)
  );

  assign in_ready = in_ready_q;
  assign out_data = main_data;
  assign out_adr  = main_adr;
  assign out_ctrl = out_valid ? main_ctrl : CTRL_W'(CTRL_BUBBLE);
  assign occ      = state_q;

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the data payload (ALU result, store data, and similar fields concatenated by the instantiator).
REQ-002 Parameter CTRL_W, default 4, width of the control payload; an all-zero value means a bubble (no memory or register write).
REQ-003 Parameter ADR_W, default 5, width of the destination register address.
REQ-004 Reset is rst, asynchronous, active-high; the clock is clk.
REQ-005 Ports, as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage accepts an entry; registered
- in_data  in  DATA_W  upstream data
- in_adr  in  ADR_W  upstream destination address
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  data
- out_adr  out  ADR_W  address
- out_ctrl  out  CTRL_W  control
- occ  out  2  entries held (0..2)

Function
REQ-006 A transfer on the input side (in_fire) is in_valid & in_ready at a rising clk edge.
REQ-007 A transfer on the output side (out_fire) is out_valid & out_ready at a rising clk edge.
REQ-008 Storage is two entries: main (drives the outputs) and skid; each entry holds data, address and control.
REQ-009 The state machine has three states: EMPTY (occ=0), ONE (occ=1, main valid), FULL (occ=2, main and skid valid).
REQ-010 In EMPTY, in_fire loads main and moves to ONE.
REQ-011 In ONE:
- in_fire with no out_fire loads skid and moves to FULL;
- out_fire with no in_fire moves to EMPTY;
- in_fire and out_fire together load main from the input and stay in ONE.
REQ-012 In FULL, out_fire copies skid into main and moves to ONE; no in_fire is possible because in_ready is 0.
REQ-013 in_ready is registered and equals 1 exactly when the next state is not FULL; it has no combinational path from out_ready.
REQ-014 out_valid is 1 exactly in ONE and FULL.
REQ-015 out_data, out_adr and out_ctrl come directly from main.
REQ-016 out_ctrl is forced to all-zero whenever out_valid is 0.
REQ-017 Latency: an entry accepted into EMPTY appears on the outputs on the cycle after in_fire.
REQ-018 Throughput: one entry per cycle when out_ready is held at 1.
REQ-019 Entry order is strictly FIFO; no entry is duplicated or dropped unless flush is asserted.
REQ-020 When out_valid=1 and out_ready=0, the outputs hold stable until out_fire.
REQ-021 Flush has highest priority: the next state is EMPTY, main and skid control are cleared to zero, and any coincident in_fire entry is discarded.
REQ-022 Flush leaves data and address registers unchanged; they are don't-care.
REQ-023 On the cycle after flush, in_ready is 1.
REQ-024 Flush in EMPTY has no effect beyond clearing control.
REQ-025 The stage has no width arithmetic; payloads pass through bit-exact.

Reset
REQ-026 While rst is high, all of the following are cleared:
- state EMPTY, occ 0;
- main and skid data, address and control all zero;
- out_valid 0, in_ready 1.
REQ-027 Reset mid-operation discards all held entries immediately, without waiting for a clock edge.
REQ-028 The first in_fire after rst deasserts behaves as in EMPTY.

Structure
REQ-029 A shared package pipe_pkg holds:
- the state enum (EMPTY, ONE, FULL);
- the default DATA_W, CTRL_W and ADR_W;
- the bubble constant (all-zero control).
REQ-030 A single sub-module, pipe_skid_entry, is a load-enabled register for {data, adr, ctrl} with async reset and a synchronous ctrl clear; it is instantiated twice (main, skid).
REQ-031 No other sub-modules are used.

Verification
REQ-032 Streaming: with out_ready=1, in_valid=1 and data 1,2,3,4 on consecutive cycles, out_data shows 1,2,3,4 one cycle later, occ stays 1, and in_ready stays 1.
REQ-033 Backpressure: with out_ready=0, inputs 0xA then 0xB give occ=2 and in_ready=0; in_valid held with 0xC is not accepted; after out_ready=1 the outputs show 0xA, 0xB, 0xC in order with no loss.
REQ-034 Flush while FULL with ctrl=4'hF, with in_valid=1 on the same cycle, gives next cycle occ=0, out_valid=0, out_ctrl=0 and in_ready=1; the incoming entry never appears.
REQ-035 Async reset asserted mid-cycle while in ONE clears out_valid, out_ctrl, out_data and occ before the next clk edge.
REQ-036 Random bench: random in_valid and out_ready over 10,000 cycles with a scoreboard checks FIFO order, in_ready never combinationally following out_ready, and out_ctrl=0 whenever out_valid=0.
